// File: rtl/l1d_package.sv
// Shared L1D types and widths: entry-state and issue-state enums, bus widths,
// and a helper that picks one 64-bit beat out of a cache line.
package l1d_package;

    localparam int L1D_MSHR_ID_WIDTH = 4;
    localparam int L1D_ADDR_WIDTH    = 40;
    localparam int L1D_LINE_WIDTH    = 512;
    localparam int L1D_BEAT_WIDTH    = 64;

    typedef enum logic [1:0] {
        WB_FREE = 2'd0,
        WB_PEND = 2'd1,
        WB_SENT = 2'd2
    } wb_entry_state_e;

    typedef enum logic [1:0] {
        ISS_IDLE = 2'd0,
        ISS_AW   = 2'd1,
        ISS_W    = 2'd2
    } wb_issue_state_e;

    function automatic logic [L1D_BEAT_WIDTH-1:0] line_beat(
        input logic [L1D_LINE_WIDTH-1:0] line,
        input int unsigned               k
    );
        return line[L1D_BEAT_WIDTH*k +: L1D_BEAT_WIDTH];
    endfunction

endpackage

// File: rtl/l1d_wb_order_fifo.sv
// Issue-order FIFO for the write-back buffer: holds entry indices in the
// order lines were accepted. DEPTH must be a power of two.
module l1d_wb_order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    // Storage array, payload only, no reset needed
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/l1d_wb_buffer.sv
// L1D dirty-line write-back buffer: stores evicted lines and issues them as
// AXI AW + LINE_BEATS-beat W bursts in acceptance order. Optional address
// lookup port is enabled by defining L1D_WB_LOOKUP_EN.
module l1d_wb_buffer
    import l1d_package::*;
#(
    parameter int WB_ENTRIES = 4,
    parameter int LINE_BEATS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         evict_req_vld,
    output logic                         evict_req_rdy,
    input  logic [L1D_MSHR_ID_WIDTH-1:0] evict_req_id,
    input  logic [L1D_ADDR_WIDTH-1:0]    evict_req_addr,
    input  logic [L1D_LINE_WIDTH-1:0]    evict_req_data,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [L1D_ADDR_WIDTH-1:0]    axi_awaddr,
    output logic [L1D_MSHR_ID_WIDTH-1:0] axi_awid,
    output logic [7:0]                   axi_awlen,
    output logic [2:0]                   axi_awsize,
    output logic                         axi_wvalid,
    input  logic                         axi_wready,
    output logic [L1D_BEAT_WIDTH-1:0]    axi_wdata,
    output logic [7:0]                   axi_wstrb,
    output logic                         axi_wlast,
    input  logic                         evict_done_en,
    input  logic [L1D_MSHR_ID_WIDTH-1:0] evict_done_id,
    output logic                         wb_empty,
    output logic                         wb_err
`ifdef L1D_WB_LOOKUP_EN
    ,
    input  logic [L1D_ADDR_WIDTH-1:0]    lookup_addr,
    output logic                         lookup_hit
`endif
);

    localparam int IW = $clog2(WB_ENTRIES);
    localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

    wb_entry_state_e              ent_state_q [WB_ENTRIES];
    wb_entry_state_e              ent_state_d [WB_ENTRIES];
    logic [L1D_MSHR_ID_WIDTH-1:0] ent_id_q    [WB_ENTRIES];
    logic [L1D_ADDR_WIDTH-1:0]    ent_addr_q  [WB_ENTRIES];
    logic [L1D_BEAT_WIDTH-1:0]    ent_data_q  [WB_ENTRIES][LINE_BEATS];

    wb_issue_state_e iss_state_q, iss_state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            wb_err_q, wb_err_d;

    logic            any_free_s;
    logic            all_free_s;
    logic [IW-1:0]   alloc_idx_s;
    logic            alloc_fire_s;
    logic            done_hit_s;
    logic [IW-1:0]   done_idx_s;
    logic            fifo_empty_s;
    logic [IW-1:0]   head_idx_s;
    logic            last_hs_s;

    // Lowest-index FREE entry and occupancy summary, from registered state only
    always_comb begin
        any_free_s  = 1'b0;
        all_free_s  = 1'b1;
        alloc_idx_s = '0;
        for (int i = WB_ENTRIES - 1; i >= 0; i--) begin
            any_free_s  = any_free_s | (ent_state_q[i] == WB_FREE);
            all_free_s  = all_free_s & (ent_state_q[i] == WB_FREE);
            alloc_idx_s = (ent_state_q[i] == WB_FREE) ? IW'(i) : alloc_idx_s;
        end
    end

    assign alloc_fire_s = evict_req_vld & any_free_s;

    // Match a B completion against SENT entries
    always_comb begin
        done_hit_s = 1'b0;
        done_idx_s = '0;
        for (int i = WB_ENTRIES - 1; i >= 0; i--) begin
            done_hit_s = done_hit_s | (evict_done_en && ent_state_q[i] == WB_SENT &&
                                       ent_id_q[i] == evict_done_id);
            done_idx_s = (evict_done_en && ent_state_q[i] == WB_SENT &&
                          ent_id_q[i] == evict_done_id) ? IW'(i) : done_idx_s;
        end
    end

    // Per-entry next state; allocate, send and free always target distinct entries
    always_comb begin
        for (int i = 0; i < WB_ENTRIES; i++) begin
            ent_state_d[i] = ent_state_q[i];
            if (alloc_fire_s && alloc_idx_s == IW'(i)) begin
                ent_state_d[i] = WB_PEND;
            end else if (last_hs_s && head_idx_s == IW'(i)) begin
                ent_state_d[i] = WB_SENT;
            end else if (done_hit_s && done_idx_s == IW'(i)) begin
                ent_state_d[i] = WB_FREE;
            end else begin
                ent_state_d[i] = ent_state_q[i];
            end
        end
    end

    // Entry state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_ENTRIES; i++) begin
                ent_state_q[i] <= WB_FREE;
            end
        end else begin
            for (int i = 0; i < WB_ENTRIES; i++) begin
                ent_state_q[i] <= ent_state_d[i];
            end
        end
    end

    // Entry payload capture on allocation
    always_ff @(posedge clk) begin
        for (int i = 0; i < WB_ENTRIES; i++) begin
            if (alloc_fire_s && alloc_idx_s == IW'(i)) begin
                ent_id_q[i]   <= evict_req_id;
                ent_addr_q[i] <= evict_req_addr;
                for (int b = 0; b < LINE_BEATS; b++) begin
                    ent_data_q[i][b] <= line_beat(evict_req_data, b);
                end
            end
        end
    end

    l1d_wb_order_fifo #(
        .DEPTH (WB_ENTRIES),
        .WIDTH (IW)
    ) u_order_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (alloc_fire_s),
        .push_data_i (alloc_idx_s),
        .pop_i       (last_hs_s),
        .head_o      (head_idx_s),
        .empty_o     (fifo_empty_s)
    );

    // Issue FSM next state; a push this cycle lets IDLE leave without waiting
    // a cycle for the FIFO to show non-empty
    always_comb begin
        iss_state_d = iss_state_q;
        beat_d      = beat_q;
        last_hs_s   = 1'b0;
        case (iss_state_q)
            ISS_IDLE: begin
                if (!fifo_empty_s || alloc_fire_s) begin
                    iss_state_d = ISS_AW;
                end else begin
                    iss_state_d = ISS_IDLE;
                end
            end
            ISS_AW: begin
                if (axi_awready) begin
                    iss_state_d = ISS_W;
                end else begin
                    iss_state_d = ISS_AW;
                end
            end
            ISS_W: begin
                if (axi_wready && beat_q == LAST_BEAT) begin
                    last_hs_s   = 1'b1;
                    beat_d      = '0;
                    iss_state_d = ISS_IDLE;
                end else if (axi_wready) begin
                    beat_d = beat_q + BW'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                iss_state_d = ISS_IDLE;
                beat_d      = '0;
            end
        endcase
    end

    assign wb_err_d = wb_err_q | (evict_done_en & ~done_hit_s);

    // Issue FSM, beat counter and sticky error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_state_q <= ISS_IDLE;
            beat_q      <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            iss_state_q <= iss_state_d;
            beat_q      <= beat_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign evict_req_rdy = any_free_s;
    assign wb_empty      = all_free_s;
    assign wb_err        = wb_err_q;

    assign axi_awvalid = (iss_state_q == ISS_AW);
    assign axi_awaddr  = ent_addr_q[head_idx_s];
    assign axi_awid    = ent_id_q[head_idx_s];
    assign axi_awlen   = 8'(LINE_BEATS - 1);
    assign axi_awsize  = 3'd3;
    assign axi_wvalid  = (iss_state_q == ISS_W);
    assign axi_wdata   = ent_data_q[head_idx_s][beat_q];
    assign axi_wstrb   = 8'hFF;
    assign axi_wlast   = (iss_state_q == ISS_W) && (beat_q == LAST_BEAT);

`ifdef L1D_WB_LOOKUP_EN
    // Address hit against any line still owned by the buffer
    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < WB_ENTRIES; i++) begin
            lookup_hit = lookup_hit |
                         ((ent_state_q[i] != WB_FREE) && (ent_addr_q[i] == lookup_addr));
        end
    end
`endif

endmodule

// File: tb/tb_l1d_wb_buffer.sv
// Self-checking bench for l1d_wb_buffer: directed scenarios plus a random
// phase, all checked against an entry/queue reference model.
module tb_l1d_wb_buffer;
    import l1d_package::*;

    localparam int WB = 4;
    localparam int LB = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         evict_req_vld;
    logic         evict_req_rdy;
    logic [3:0]   evict_req_id;
    logic [39:0]  evict_req_addr;
    logic [511:0] evict_req_data;
    logic         axi_awvalid, axi_awready;
    logic [39:0]  axi_awaddr;
    logic [3:0]   axi_awid;
    logic [7:0]   axi_awlen;
    logic [2:0]   axi_awsize;
    logic         axi_wvalid, axi_wready;
    logic [63:0]  axi_wdata;
    logic [7:0]   axi_wstrb;
    logic         axi_wlast;
    logic         evict_done_en;
    logic [3:0]   evict_done_id;
    logic         wb_empty, wb_err;

    always #5 clk = ~clk;

    l1d_wb_buffer #(.WB_ENTRIES(WB), .LINE_BEATS(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .evict_req_vld(evict_req_vld), .evict_req_rdy(evict_req_rdy),
        .evict_req_id(evict_req_id), .evict_req_addr(evict_req_addr),
        .evict_req_data(evict_req_data),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr), .axi_awid(axi_awid),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .evict_done_en(evict_done_en), .evict_done_id(evict_done_id),
        .wb_empty(wb_empty), .wb_err(wb_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: 0=free 1=pending 2=sent, queue of entries awaiting issue
    int          m_st   [WB];
    logic [3:0]  m_id   [WB];
    logic [39:0] m_addr [WB];
    logic [63:0] m_data [WB][LB];
    int          q_issue[$];
    bit          m_inw;
    int          m_beat;
    bit          m_err;
    int          sent_total = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < WB; i++) m_st[i] = 0;
        q_issue.delete();
        m_inw = 0; m_beat = 0; m_err = 0;
    endtask

    function automatic int count_state(input int s);
        int c = 0;
        for (int i = 0; i < WB; i++) if (m_st[i] == s) c++;
        return c;
    endfunction

    function automatic logic [3:0] unused_id();
        int start = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] c = 4'((start + k) % 16);
            bit live = 0;
            for (int i = 0; i < WB; i++) if (m_st[i] != 0 && m_id[i] == c) live = 1;
            if (!live) return c;
        end
        return 4'd0;
    endfunction

    task automatic set_req(input logic [3:0] id);
        logic [39:0]  a;
        logic [511:0] d;
        a = 40'({$urandom(), $urandom()}) & ~40'h3F;
        for (int b = 0; b < LB; b++) d[64*b +: 64] = {$urandom(), $urandom()};
        evict_req_vld = 1'b1; evict_req_id = id; evict_req_addr = a; evict_req_data = d;
    endtask

    // Check outputs against the model, advance one clock, update the model
    task automatic cycle();
        bit any_free, all_free, acc, awhs, whs, dhit;
        int fi, dj, hd;
        any_free = 0; all_free = 1; fi = -1;
        for (int i = 0; i < WB; i++) begin
            if (m_st[i] == 0) begin
                any_free = 1;
                if (fi < 0) fi = i;
            end else all_free = 0;
        end
        hd = (q_issue.size() > 0) ? q_issue[0] : 0;
        chk("rdy", 64'(evict_req_rdy), 64'(any_free));
        chk("wb_empty", 64'(wb_empty), 64'(all_free));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        chk("aw_w_exclusive", 64'(axi_awvalid & axi_wvalid), 64'd0);
        if (axi_awvalid === 1'b1) begin
            chk("aw_while_pending", 64'(q_issue.size() > 0 && !m_inw), 64'd1);
            chk("awaddr", 64'(axi_awaddr), 64'(m_addr[hd]));
            chk("awid", 64'(axi_awid), 64'(m_id[hd]));
            chk("awlen", 64'(axi_awlen), 64'(LB - 1));
            chk("awsize", 64'(axi_awsize), 64'd3);
        end
        if (axi_wvalid === 1'b1) begin
            chk("w_after_aw", 64'(m_inw), 64'd1);
            chk("wdata", axi_wdata, m_data[hd][m_beat]);
            chk("wlast", 64'(axi_wlast), 64'(m_beat == LB - 1));
            chk("wstrb", 64'(axi_wstrb), 64'hFF);
        end else begin
            chk("wlast_idle", 64'(axi_wlast), 64'd0);
        end
        acc  = evict_req_vld && any_free;
        awhs = (axi_awvalid === 1'b1) && axi_awready && q_issue.size() > 0 && !m_inw;
        whs  = (axi_wvalid === 1'b1) && axi_wready && m_inw;
        dhit = 0; dj = 0;
        if (evict_done_en)
            for (int i = 0; i < WB; i++)
                if (!dhit && m_st[i] == 2 && m_id[i] == evict_done_id) begin dhit = 1; dj = i; end
        @(posedge clk); #1;
        if (awhs) begin m_inw = 1; m_beat = 0; end
        if (whs) begin
            if (m_beat == LB - 1) begin
                m_st[hd] = 2; void'(q_issue.pop_front()); m_inw = 0; m_beat = 0; sent_total++;
            end else m_beat++;
        end
        if (evict_done_en) begin
            if (dhit) m_st[dj] = 0;
            else m_err = 1;
        end
        if (acc) begin
            m_st[fi] = 1; m_id[fi] = evict_req_id; m_addr[fi] = evict_req_addr;
            for (int b = 0; b < LB; b++) m_data[fi][b] = evict_req_data[64*b +: 64];
            q_issue.push_back(fi);
        end
    endtask

    task automatic free_id(input logic [3:0] id);
        evict_done_en = 1'b1; evict_done_id = id;
        cycle();
        evict_done_en = 1'b0;
    endtask

    initial begin
        logic [3:0] ids [4];
        int n, start, ph;
        ids[0] = 4'd0; ids[1] = 4'd1; ids[2] = 4'd2; ids[3] = 4'd5;
        rst_n = 1'b0; evict_req_vld = 1'b0; evict_req_id = '0; evict_req_addr = '0;
        evict_req_data = '0; axi_awready = 1'b1; axi_wready = 1'b1;
        evict_done_en = 1'b0; evict_done_id = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_awvalid", 64'(axi_awvalid), 64'd0);
        chk("reset_wvalid", 64'(axi_wvalid), 64'd0);
        chk("reset_wlast", 64'(axi_wlast), 64'd0);
        chk("reset_rdy", 64'(evict_req_rdy), 64'd1);
        chk("reset_empty", 64'(wb_empty), 64'd1);
        chk("reset_err", 64'(wb_err), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Single eviction, exact latency
        set_req(4'd3); evict_req_addr = 40'h1000;
        cycle();
        evict_req_vld = 1'b0;
        chk("single_aw_T+1", 64'(axi_awvalid), 64'd1);
        cycle();
        for (int k = 0; k < LB; k++) begin
            chk("single_wvalid_beat", 64'(axi_wvalid), 64'd1);
            chk("single_wlast_beat", 64'(axi_wlast), 64'(k == LB - 1));
            cycle();
        end
        chk("single_wvalid_after", 64'(axi_wvalid), 64'd0);
        free_id(4'd3);
        chk("single_empty_after_done", 64'(wb_empty), 64'd1);

        // Four back-to-back evicts fill the buffer
        for (int k = 0; k < 4; k++) begin
            set_req(ids[k]);
            cycle();
        end
        evict_req_vld = 1'b0;
        chk("full_rdy_low", 64'(evict_req_rdy), 64'd0);
        n = 0;
        while (count_state(2) < 4 && n < 200) begin
            axi_awready = 1'($urandom_range(0, 1)); axi_wready = 1'($urandom_range(0, 1));
            cycle(); n++;
        end
        chk("full_all_sent", 64'(count_state(2)), 64'd4);
        axi_awready = 1'b1; axi_wready = 1'b1;

        // Free and allocate in the same cycle while full
        set_req(4'd7);
        evict_done_en = 1'b1; evict_done_id = 4'd1;
        chk("same_cycle_rdy_low", 64'(evict_req_rdy), 64'd0);
        cycle();
        evict_done_en = 1'b0;
        chk("freed_rdy_high", 64'(evict_req_rdy), 64'd1);
        cycle();
        evict_req_vld = 1'b0;
        chk("refilled_rdy_low", 64'(evict_req_rdy), 64'd0);
        n = 0;
        while ((q_issue.size() > 0 || m_inw) && n < 40) begin cycle(); n++; end
        chk("refill_drained", 64'(q_issue.size()), 64'd0);
        free_id(4'd0); free_id(4'd2); free_id(4'd5); free_id(4'd7);
        chk("drain_empty", 64'(wb_empty), 64'd1);

        // wready toggling 1,0,1,0 during the data phase
        set_req(4'd6);
        cycle();
        evict_req_vld = 1'b0;
        start = sent_total; ph = 1; n = 0;
        while (sent_total == start && n < 40) begin
            axi_wready = 1'(ph); ph ^= 1;
            cycle(); n++;
        end
        chk("toggle_burst_done", 64'(sent_total), 64'(start + 1));
        axi_wready = 1'b1;

        // Completion with an id that matches nothing
        free_id(4'd9);
        chk("bad_done_err", 64'(wb_err), 64'd1);
        repeat (3) cycle();
        chk("bad_done_err_sticky", 64'(wb_err), 64'd1);
        chk("bad_done_state_kept", 64'(wb_empty), 64'd0);
        free_id(4'd6);
        chk("bad_done_then_free", 64'(wb_empty), 64'd1);

        // Reset during beat 4 abandons the burst
        set_req(4'd4);
        cycle();
        evict_req_vld = 1'b0;
        n = 0;
        while (!(m_inw && m_beat == 4) && n < 20) begin cycle(); n++; end
        chk("reached_beat4", 64'(m_beat), 64'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_wvalid", 64'(axi_wvalid), 64'd0);
        chk("midreset_awvalid", 64'(axi_awvalid), 64'd0);
        chk("midreset_empty", 64'(wb_empty), 64'd1);
        chk("midreset_rdy", 64'(evict_req_rdy), 64'd1);
        chk("midreset_err", 64'(wb_err), 64'd0);
        model_clear();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Random traffic
        for (int r = 0; r < 500; r++) begin
            axi_awready = ($urandom_range(0, 3) != 0);
            axi_wready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) set_req(unused_id());
            else evict_req_vld = 1'b0;
            evict_done_en = 1'b0;
            if (count_state(2) > 0 && $urandom_range(0, 2) == 0) begin
                int pick = $urandom_range(0, count_state(2) - 1);
                for (int i = 0; i < WB; i++) begin
                    if (m_st[i] == 2) begin
                        if (pick == 0) begin evict_done_en = 1'b1; evict_done_id = m_id[i]; end
                        pick--;
                    end
                end
            end
            cycle();
        end
        evict_req_vld = 1'b0; evict_done_en = 1'b0;
        chk("random_progress", 64'(sent_total > 10), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
